// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer with valid-qualified bits, frame resync,
// a valid/ready holding register for completed words, and a sticky overrun flag.
// Ports:
//   clk, reset (sync, active-high)
//   sin, sin_valid, frame_start : serial input side
//   q, q_valid, q_ready         : word output handshake
//   bit_cnt                     : bits in the current partial word
//   overrun, ovr_clr            : sticky drop flag and its clear
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun,
  input  logic             ovr_clr
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qv_q, qv_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shifted;
  logic             done;
  logic             drop;

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sr_q[WIDTH-2:0], sin};
    end else begin
      shifted = {sin, sr_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    word_d = word_q;
    qv_d   = qv_q;
    ovr_d  = ovr_q;
    done   = 1'b0;
    drop   = 1'b0;

    // Old bits left in sr after a resync are shifted out before the
    // next completion, so only the counter needs restarting.
    if (frame_start) begin
      if (sin_valid) begin
        sr_d  = shifted;
        cnt_d = CW'(1);
      end else begin
        cnt_d = '0;
      end
    end else if (sin_valid) begin
      sr_d = shifted;
      if (cnt_q == CW'(WIDTH-1)) begin
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    drop = done && qv_q && !q_ready;

    if (done && !drop) begin
      word_d = shifted;
      qv_d   = 1'b1;
    end else if (qv_q && q_ready) begin
      qv_d = 1'b0;
    end

    // A drop on the same edge as a clear keeps the flag set.
    if (ovr_clr) begin
      ovr_d = 1'b0;
    end
    if (drop) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      qv_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      word_q <= word_d;
      qv_q   <= qv_d;
      ovr_q  <= ovr_d;
    end
  end

  assign q       = word_q;
  assign q_valid = qv_q;
  assign bit_cnt = cnt_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Testbench for sipo_deserializer: two instances (MSB-first and LSB-first)
// share one stimulus stream and are checked against a queue-based model.
module tb_sipo_deserializer;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic clk = 1'b0;
  logic reset, sin, sin_valid, frame_start, q_ready, ovr_clr;
  logic [W-1:0]  q_m, q_l;
  logic          qv_m, qv_l, ovr_m, ovr_l;
  logic [CW-1:0] cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
    .frame_start(frame_start), .q(q_m), .q_valid(qv_m),
    .q_ready(q_ready), .bit_cnt(cnt_m), .overrun(ovr_m),
    .ovr_clr(ovr_clr)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
    .frame_start(frame_start), .q(q_l), .q_valid(qv_l),
    .q_ready(q_ready), .bit_cnt(cnt_l), .overrun(ovr_l),
    .ovr_clr(ovr_clr)
  );

  // Reference model: bits of the current word in arrival order.
  bit           bits[$];
  logic [W-1:0] mq_m = '0;
  logic [W-1:0] mq_l = '0;
  logic         mv   = 1'b0;
  logic         mo   = 1'b0;

  function automatic logic [W-1:0] pack(input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) w[W-1-i] = bits[i];
      else     w[i]     = bits[i];
    end
    return w;
  endfunction

  task automatic model(input logic s, v, f, r, c, rs);
    bit done;
    bit drop;
    logic [W-1:0] wm, wl;
    done = 0;
    wm = '0;
    wl = '0;
    if (rs) begin
      bits.delete();
      mq_m = '0;
      mq_l = '0;
      mv = 0;
      mo = 0;
      return;
    end
    if (f) begin
      bits.delete();
      if (v) bits.push_back(s);
    end else if (v) begin
      bits.push_back(s);
      if (bits.size() == W) begin
        done = 1;
        wm = pack(1'b1);
        wl = pack(1'b0);
        bits.delete();
      end
    end
    drop = done && mv && !r;
    if (done && !drop) begin
      mq_m = wm;
      mq_l = wl;
      mv = 1;
    end else if (mv && r) begin
      mv = 0;
    end
    if (c) mo = 0;
    if (drop) mo = 1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] ec;
    ec = 32'(bits.size());
    check("q_msb", 32'(q_m), 32'(mq_m));
    check("q_lsb", 32'(q_l), 32'(mq_l));
    check("qv_msb", 32'(qv_m), 32'(mv));
    check("qv_lsb", 32'(qv_l), 32'(mv));
    check("cnt_msb", 32'(cnt_m), ec);
    check("cnt_lsb", 32'(cnt_l), ec);
    check("ovr_msb", 32'(ovr_m), 32'(mo));
    check("ovr_lsb", 32'(ovr_l), 32'(mo));
  endtask

  task automatic step(input logic s, v, f, r, c, rs);
    sin = s;
    sin_valid = v;
    frame_start = f;
    q_ready = r;
    ovr_clr = c;
    reset = rs;
    @(posedge clk);
    model(s, v, f, r, c, rs);
    #1;
    check_all();
  endtask

  task automatic send(input logic [W-1:0] b, input logic r, input bit gap);
    for (int i = W - 1; i >= 0; i--) begin
      step(b[i], 1'b1, 1'b0, r, 1'b0, 1'b0);
      if (gap && i != 0) step(1'b0, 1'b0, 1'b0, r, 1'b0, 1'b0);
    end
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("rst_q", 32'(q_m), 0);
    check("rst_cnt", 32'(cnt_m), 0);

    send(8'hB2, 1'b1, 0);
    check("ord_msb", 32'(q_m), 32'hB2);
    check("ord_lsb", 32'(q_l), 32'h4D);
    check("ord_qv", 32'(qv_m), 1);
    step(0, 0, 0, 1, 0, 0);
    check("ord_pulse", 32'(qv_m), 0);

    send(8'hB2, 1'b1, 1);
    check("gap_msb", 32'(q_m), 32'hB2);

    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    check("fs_cnt", 32'(cnt_m), 1);
    for (int i = 0; i < 7; i++) step(logic'(~i[0]), 1, 0, 1, 0, 0);
    check("fs_msb", 32'(q_m), 32'h55);
    check("fs_lsb", 32'(q_l), 32'hAA);
    step(0, 0, 0, 1, 0, 0);

    send(8'hB2, 1'b0, 0);
    send(8'h0F, 1'b0, 0);
    check("bp_q", 32'(q_m), 32'hB2);
    check("bp_ovr", 32'(ovr_m), 1);
    step(0, 0, 0, 1, 0, 0);
    check("bp_drain", 32'(qv_m), 0);
    step(0, 0, 0, 0, 1, 0);
    check("bp_clr", 32'(ovr_m), 0);

    send(8'h3C, 1'b0, 0);
    for (int i = W - 1; i >= 0; i--) begin
      logic [W-1:0] b;
      b = 8'hC3;
      step(b[i], 1, 0, logic'(i == 0), 0, 0);
    end
    check("sim_q", 32'(q_m), 32'hC3);
    check("sim_qv", 32'(qv_m), 1);
    check("sim_ovr", 32'(ovr_m), 0);

    for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 1);
    check("mid_cnt", 32'(cnt_m), 0);
    check("mid_qv", 32'(qv_m), 0);
    send(8'h96, 1'b1, 0);
    check("post_rst", 32'(q_m), 32'h96);

    for (int n = 0; n < 3000; n++) begin
      step(logic'($urandom_range(1)),
           logic'($urandom_range(3) != 0),
           logic'($urandom_range(15) == 0),
           logic'($urandom_range(1)),
           logic'($urandom_range(7) == 0),
           logic'($urandom_range(63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
